ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  RV32M multiply/divide unit in the EX stage, fed by ID/EX register outputs (READ_DATA1/2, ALU_OP).
//  Multi-cycle: stalls IF/ID/ID-EX via STALL while busy, then presents a 32-bit result to the EX/MEM mux.
//  Handles all 8 M-extension ops, including RISC-V divide-by-zero and signed-overflow semantics.
// PARAMETERS
//  XLEN      32   operand/result width; only 32 is supported
//  CNT_W     6    iteration counter width; must hold XLEN
// PORTS
//  CLK        in   1     clock, rising edge
//  RESET      in   1     synchronous, active-high reset
//  START      in   1     request; sampled only in IDLE
//  ALU_OP     in   5     op code; only MUL..REMU from muldiv_defs.vh are accepted
//  OPERAND_A  in   32    rs1 value (forwarded)
//  OPERAND_B  in   32    rs2 value (forwarded)
//  FLUSH      in   1     abort in-flight op (branch/jump taken)
//  STALL      out  1     hold upstream pipeline registers
//  DONE       out  1     one-cycle result-valid pulse
//  RESULT     out  32    result; valid while DONE=1, held until next DONE
// BEHAVIOUR
//  Reset: state=IDLE; STALL=0, DONE=0, RESULT=0; counter and work regs cleared. Applies mid-operation too.
//  Cycle N = cycle in which START=1 is sampled in IDLE with a valid op.
//  A non-M ALU_OP with START=1 is ignored: stays IDLE, STALL=0.
//  STALL = (START & valid op & state==IDLE) | (state in MUL, DIV, FIX). It is 0 in the DONE cycle.
//  FSM: IDLE -> MUL -> DONE (MUL, MULH, MULHSU, MULHU).
//       IDLE -> DIV(32 iters) -> FIX -> DONE (DIV, DIVU, REM, REMU).
//       IDLE -> DONE special-case fast path.
//       DONE -> IDLE unconditionally.
//  MUL*: 64-bit product of sign/zero-extended operands (MULHSU: A signed, B unsigned).
//    MUL returns [31:0]; MULH* return [63:32]. DONE in cycle N+2.
//  DIV*: radix-2 restoring divide on absolute values, one quotient bit per cycle, counter XLEN-1 down to 0.
//    FIX applies signs: quotient negated if signs differ; remainder takes the sign of the dividend.
//    DONE in cycle N+34.
//  Special cases, resolved in IDLE, DONE in cycle N+1:
//    B==0: quotient=32'hFFFF_FFFF, remainder=A.
//    signed A==32'h8000_0000 & B==-1: quotient=32'h8000_0000, remainder=0.
//  START while not IDLE is ignored. Operands and op are latched at accept; later input changes have no effect.
//  FLUSH in any non-IDLE state: next state IDLE, no DONE, RESULT unchanged.
//  FLUSH with START in the same cycle: FLUSH wins, request not accepted.
//  RESET has priority over FLUSH and START.
// CONFIGURATION
//  MULDIV_REM_CACHE_EN defined:
//    Store the last completed divide's A, B, signedness, quotient and remainder.
//    A DIV/REM (or DIVU/REMU) with the same A, B and signedness takes the fast path, DONE in N+1.
//    The cache is invalidated by RESET and FLUSH.
//  Not defined: no cache; every divide takes the full latency.
// STRUCTURE
//  muldiv_defs.vh holds the ALU_OP codes MUL..REMU, the FSM state encodings and XLEN.
//    ID-stage control unit includes the same file.
//  Sub-module div_core: iterative unsigned divider (load, step, quotient/remainder regs).
//    The top holds the FSM, multiplier, sign handling and the optional cache.
// TESTING
//  MUL A=7, B=-3 -> DONE at N+2, RESULT=32'hFFFF_FFEB; STALL high in N and N+1 only.
//  MULHU A=B=32'hFFFF_FFFF -> RESULT=32'hFFFF_FFFE.
//    MULH on the same operands -> RESULT=0.
//  DIV A=-20, B=3 -> DONE at N+34, RESULT=-6; REM on the same operands -> RESULT=-2.
//  DIVU A=100, B=0 -> DONE at N+1, RESULT=32'hFFFF_FFFF.
//    REM A=32'h8000_0000, B=-1 -> RESULT=0.
//  DIVU 1000/7 with FLUSH at N+10 -> IDLE at N+11, no DONE.
//    Then START same op -> RESULT=142 at new N+34.
//  MULDIV_REM_CACHE_EN: DIV 50/8 then REM 50/8 -> second DONE at N+1, RESULT=2.
//    Without the macro -> second DONE at N+34.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: ALU_OP codes,
// FSM state encoding, widths and small op-decode helpers. The ID-stage
// control unit imports the same package so both agree on the op codes.
package ex_muldiv_unit_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int CNT_W_DEF = 6;

    // M-extension op codes (upper half of the 5-bit ALU_OP space)
    localparam logic [4:0] OP_MUL    = 5'h10;
    localparam logic [4:0] OP_MULH   = 5'h11;
    localparam logic [4:0] OP_MULHSU = 5'h12;
    localparam logic [4:0] OP_MULHU  = 5'h13;
    localparam logic [4:0] OP_DIV    = 5'h14;
    localparam logic [4:0] OP_DIVU   = 5'h15;
    localparam logic [4:0] OP_REM    = 5'h16;
    localparam logic [4:0] OP_REMU   = 5'h17;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Any of the eight M ops
    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // DIV, DIVU, REM, REMU
    function automatic logic is_div_op(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

    // Signed divide/remainder
    function automatic logic is_signed_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder-producing ops
    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_core.sv
// Iterative radix-2 restoring divider on unsigned operands. One quotient
// bit per step; the counter runs XLEN-1 down to 0 and 'last' flags the
// final step so the owner can move on after exactly XLEN steps.
module ex_muldiv_unit_div_core
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
)
(
    input  logic            clk,
    input  logic            srst,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            last
);

    logic [XLEN-1:0]  quo_reg;
    logic [XLEN-1:0]  rem_reg;
    logic [XLEN-1:0]  dsr_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [XLEN:0] shifted_next;
    logic [XLEN:0] diff_next;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted_next = {rem_reg, quo_reg[XLEN-1]};
        diff_next    = shifted_next - {1'b0, dsr_reg};
    end

    // Load operands, then shift one dividend bit into the remainder per step
    always_ff @(posedge clk) begin
        if (srst) begin
            quo_reg <= '0;
            rem_reg <= '0;
            dsr_reg <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            quo_reg <= dividend;
            rem_reg <= '0;
            dsr_reg <= divisor;
            cnt_reg <= CNT_W'(XLEN - 1);
        end else if (step) begin
            if (!diff_next[XLEN]) begin
                rem_reg <= diff_next[XLEN-1:0];
                quo_reg <= {quo_reg[XLEN-2:0], 1'b1};
            end else begin
                rem_reg <= shifted_next[XLEN-1:0];
                quo_reg <= {quo_reg[XLEN-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign quotient  = quo_reg;
    assign remainder = rem_reg;
    assign last      = (cnt_reg == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage. Multiplies finish in two
// cycles, divides in XLEN+2 through the iterative core, and divide-by-zero
// and signed overflow short-circuit to a one-cycle result.
// Optional feature macro: MULDIV_REM_CACHE_EN remembers the last completed
// divide so a matching DIV/REM pair reuses it on the fast path.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALU_OP,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic            FLUSH,
    output logic            STALL,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    state_t          state_reg;
    logic [4:0]      op_reg;
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic            done_reg;
    logic [XLEN-1:0] result_reg;

    logic            req_valid;
    logic            accept;
    logic            in_div;
    logic            in_signed;
    logic            in_rem;
    logic            sp_div0;
    logic            sp_ovf;
    logic            cache_hit;
    logic [XLEN-1:0] cache_q;
    logic [XLEN-1:0] cache_r;
    logic            fast;
    logic [XLEN-1:0] fast_result;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_load;
    logic            div_step;
    logic [XLEN-1:0] div_q;
    logic [XLEN-1:0] div_r;
    logic            div_last;

    logic              mul_sign_a;
    logic              mul_sign_b;
    logic [2*XLEN-1:0] mul_a_ext;
    logic [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_result;
    logic              op_signed;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   fix_result;

    // Request decode and the IDLE-resolved fast path (special cases / cache)
    always_comb begin
        req_valid = START && is_muldiv_op(ALU_OP) && (state_reg == ST_IDLE);
        accept    = req_valid && !FLUSH;
        in_div    = is_div_op(ALU_OP);
        in_signed = is_signed_div(ALU_OP);
        in_rem    = is_rem_op(ALU_OP);
        sp_div0   = (OPERAND_B == '0);
        sp_ovf    = in_signed && (OPERAND_A == {1'b1, {(XLEN-1){1'b0}}}) && (OPERAND_B == '1);
        fast      = in_div && (sp_div0 || sp_ovf || cache_hit);
        if (sp_div0)
            fast_result = in_rem ? OPERAND_A : '1;
        else if (sp_ovf)
            fast_result = in_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        else
            fast_result = in_rem ? cache_r : cache_q;
        a_abs    = (in_signed && OPERAND_A[XLEN-1]) ? -OPERAND_A : OPERAND_A;
        b_abs    = (in_signed && OPERAND_B[XLEN-1]) ? -OPERAND_B : OPERAND_B;
        div_load = accept && in_div && !fast;
        div_step = (state_reg == ST_DIV) && !FLUSH;
    end

    // Single 2*XLEN product of sign- or zero-extended latched operands
    always_comb begin
        mul_sign_a = (op_reg == OP_MULH) || (op_reg == OP_MULHSU);
        mul_sign_b = (op_reg == OP_MULH);
        mul_a_ext  = {{XLEN{mul_sign_a & a_reg[XLEN-1]}}, a_reg};
        mul_b_ext  = {{XLEN{mul_sign_b & b_reg[XLEN-1]}}, b_reg};
        mul_prod   = mul_a_ext * mul_b_ext;
        mul_result = (op_reg == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Sign restoration after the unsigned divide
    always_comb begin
        op_signed  = is_signed_div(op_reg);
        q_fix      = (op_signed && (a_reg[XLEN-1] ^ b_reg[XLEN-1])) ? -div_q : div_q;
        r_fix      = (op_signed && a_reg[XLEN-1]) ? -div_r : div_r;
        fix_result = is_rem_op(op_reg) ? r_fix : q_fix;
    end

    ex_muldiv_unit_div_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_div_core (
        .clk       (CLK),
        .srst      (RESET),
        .load      (div_load),
        .step      (div_step),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (div_q),
        .remainder (div_r),
        .last      (div_last)
    );

`ifdef MULDIV_REM_CACHE_EN
    logic            cache_valid_reg;
    logic [XLEN-1:0] cache_a_reg;
    logic [XLEN-1:0] cache_b_reg;
    logic            cache_signed_reg;
    logic [XLEN-1:0] cache_q_reg;
    logic [XLEN-1:0] cache_r_reg;

    assign cache_hit = cache_valid_reg && (cache_a_reg == OPERAND_A) &&
                       (cache_b_reg == OPERAND_B) && (cache_signed_reg == in_signed);
    assign cache_q   = cache_q_reg;
    assign cache_r   = cache_r_reg;

    // Capture both results of each divide that completes; any flush drops it
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cache_valid_reg  <= 1'b0;
            cache_a_reg      <= '0;
            cache_b_reg      <= '0;
            cache_signed_reg <= 1'b0;
            cache_q_reg      <= '0;
            cache_r_reg      <= '0;
        end else if (FLUSH) begin
            cache_valid_reg <= 1'b0;
        end else if (state_reg == ST_FIX) begin
            cache_valid_reg  <= 1'b1;
            cache_a_reg      <= a_reg;
            cache_b_reg      <= b_reg;
            cache_signed_reg <= op_signed;
            cache_q_reg      <= q_fix;
            cache_r_reg      <= r_fix;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_q   = '0;
    assign cache_r   = '0;
`endif

    // Control FSM: operand latch, sequencing, and registered DONE/RESULT
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg <= ALU_OP;
                        a_reg  <= OPERAND_A;
                        b_reg  <= OPERAND_B;
                        if (!in_div) begin
                            state_reg <= ST_MUL;
                        end else if (fast) begin
                            state_reg  <= ST_DONE;
                            done_reg   <= 1'b1;
                            result_reg <= fast_result;
                        end else begin
                            state_reg <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    if (FLUSH) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg  <= ST_DONE;
                        done_reg   <= 1'b1;
                        result_reg <= mul_result;
                    end
                end
                ST_DIV: begin
                    if (FLUSH)
                        state_reg <= ST_IDLE;
                    else if (div_last)
                        state_reg <= ST_FIX;
                end
                ST_FIX: begin
                    if (FLUSH) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg  <= ST_DONE;
                        done_reg   <= 1'b1;
                        result_reg <= fix_result;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign STALL  = req_valid || (state_reg == ST_MUL) || (state_reg == ST_DIV) ||
                    (state_reg == ST_FIX);
    assign DONE   = done_reg;
    assign RESULT = result_reg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, stall profile, results and
// flush/reset behaviour, one line per transaction.
module tb_ex_muldiv_unit;
    import ex_muldiv_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit dut (
        .CLK       (clk),
        .RESET     (rst),
        .START     (start),
        .ALU_OP    (alu_op),
        .OPERAND_A (op_a),
        .OPERAND_B (op_b),
        .FLUSH     (flush),
        .STALL     (stall),
        .DONE      (done),
        .RESULT    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and return latency (cycles after N), result and stall count.
    // Inputs are scrambled after acceptance to show they were latched.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output int stalls);
        @(negedge clk);
        start = 1'b1; alu_op = op; op_a = a; op_b = b;
        #1;
        stalls = stall ? 1 : 0;
        lat = -1;
        res = 'x;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0; alu_op = OP_MUL; op_a = ~a; op_b = a ^ b;
            #1;
            if (stall) stalls++;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        logic [31:0] res;
        run_op(op, a, b, lat, res, stalls);
        $display("%s op=%h a=%h b=%h -> result=%h latency=%0d", name, op, a, b, res, lat);
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, res, exp_res);
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; alu_op = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("reset: stall=%b done=%b result=%h", stall, done, result);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got stall=%b done=%b result=%h want 0/0/0", stall, done, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int lat;
        int stalls;
        logic [31:0] res;
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, res, stalls);
        $display("MUL 7*-3 -> result=%h latency=%0d stalls=%0d", res, lat, stalls);
        checks++;
        if (res !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mul_result: got %h want ffffffeb", res);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL mul_latency: got %0d want 2", lat);
        end
        checks++;
        if (stalls !== 2) begin
            errors++;
            $display("FAIL mul_stall_cycles: got %0d want 2", stalls);
        end
        check_op("MULHU", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
        check_op("MULH", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        check_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        check_op("MUL_lo", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2);
    endtask

    task automatic test_div();
        check_op("DIV", OP_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
        check_op("REM", OP_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
        check_op("DIVU", OP_DIVU, 32'd1000, 32'd7, 32'd142, 34);
        check_op("REMU", OP_REMU, 32'd1000, 32'd7, 32'd6, 34);
    endtask

    task automatic test_special();
        check_op("DIVU_by0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
        check_op("REMU_by0", OP_REMU, 32'd100, 32'd0, 32'd100, 1);
        check_op("REM_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        check_op("DIV_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    endtask

    task automatic test_invalid_op();
        int seen = 0;
        @(negedge clk);
        start = 1'b1; alu_op = 5'h03; op_a = 32'd5; op_b = 32'd6;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL invalid_op_stall: got %b want 0", stall);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || stall) seen++;
        end
        $display("invalid op 03 -> activity cycles=%0d", seen);
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL invalid_op_ignored: got %0d busy cycles want 0", seen);
        end
    endtask

    task automatic test_flush();
        int seen = 0;
        logic [31:0] prev;
        prev = result;
        @(negedge clk);
        start = 1'b1; alu_op = OP_DIVU; op_a = 32'd1000; op_b = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        $display("DIVU flushed at N+10: stall=%b done=%b result=%h", stall, done, result);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got stall=%b done=%b want 0/0", stall, done);
        end
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen !== 0 || result !== prev) begin
            errors++;
            $display("FAIL flush_no_done: got done=%0d result=%h want 0 / %h", seen, result, prev);
        end
        check_op("DIVU_after_flush", OP_DIVU, 32'd1000, 32'd7, 32'd142, 34);
    endtask

    task automatic test_flush_with_start();
        int seen = 0;
        @(negedge clk);
        start = 1'b1; flush = 1'b1; alu_op = OP_MUL; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_start_stall: got %b want 0", stall);
        end
        repeat (10) begin
            @(negedge clk);
            if (done) seen++;
        end
        $display("MUL with FLUSH same cycle -> done pulses=%0d", seen);
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL flush_start_ignored: got %0d done pulses want 0", seen);
        end
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        start = 1'b1; alu_op = OP_DIV; op_a = 32'd77; op_b = 32'd5;
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("reset mid-DIV: stall=%b done=%b result=%h", stall, done, result);
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_op: got stall=%b done=%b result=%h want 0/0/0", stall, done, result);
        end
    endtask

    task automatic test_cache();
        int exp_lat;
`ifdef MULDIV_REM_CACHE_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        check_op("DIV_50_8", OP_DIV, 32'd50, 32'd8, 32'd6, 34);
        check_op("REM_50_8", OP_REM, 32'd50, 32'd8, 32'd2, exp_lat);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_op("REM_50_8_after_flush", OP_REM, 32'd50, 32'd8, 32'd2, 34);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_invalid_op();
        test_flush();
        test_flush_with_start();
        test_reset_mid_op();
        test_cache();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
